// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer for one combinational netlist: LFSR patterns in, 1-bit response
// compacted into a 16-bit MISR, signature compared against a golden value at the end.
module netlist_bist_ctrl #(
    parameter int              IN_W         = 43,
    parameter int              NUM_PATTERNS = 256,
    parameter int              SETTLE_CYC   = 2,
    parameter logic [IN_W-1:0] SEED         = 43'h1,
    parameter logic [IN_W-1:0] TAPS         = 43'h630_0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [15:0]     golden_sig,
    input  logic            dut_out,
    output logic [IN_W-1:0] pattern,
    output logic [15:0]     signature,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [1:0]      state_dbg
);

    // Handshake: start is a level sampled only in IDLE/DONE, busy brackets the run
    // (high from the cycle after start through the final capture), done is a one-cycle
    // pulse with pass valid from then until the next start; abort cancels without done.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int IDX_W = $clog2(NUM_PATTERNS + 1);
    localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [IN_W-1:0]  SEED_EFF    = (SEED == '0) ? IN_W'(1) : SEED;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam state_e           FIRST_ST    = (SETTLE_CYC > 0) ? SETTLE : CAPTURE;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  pattern_d;
    logic [15:0]      sig_d;
    logic             busy_d, done_d, pass_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             lfsr_fb;
    logic [IN_W-1:0]  lfsr_next;
    logic [15:0]      misr_next;

    assign lfsr_fb   = ^(pattern & TAPS);
    assign lfsr_next = {pattern[IN_W-2:0], lfsr_fb};
    assign misr_next = {signature[14:0], 1'b0}
                     ^ (signature[15] ? 16'h1021 : 16'h0000)
                     ^ {15'b0, dut_out};

    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern;
        sig_d     = signature;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pattern_d = SEED_EFF;
                    sig_d     = 16'hFFFF;
                    idx_d     = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = FIRST_ST;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pattern_d = '0;
                    pass_d    = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                // Abort wins over completion: no MISR update and no done on this edge.
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pattern_d = '0;
                    pass_d    = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else begin
                    sig_d     = misr_next;
                    pattern_d = lfsr_next;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        pass_d  = (misr_next == golden_sig);
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FIRST_ST;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern   <= '0;
            signature <= 16'hFFFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern   <= pattern_d;
            signature <= sig_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Bench for netlist_bist_ctrl: a default-parameter instance driving a stand-in netlist
// and a single-vector instance, checked against a reference model via a done-driven scoreboard.
module tb_netlist_bist_ctrl;

    localparam int IN_W = 43;
    localparam int N_A  = 256;
    localparam int S_A  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // default-parameter instance
    logic            start_a = 1'b0, abort_a = 1'b0, noise_a = 1'b0;
    logic [15:0]     golden_a = '0;
    logic            dut_out_a;
    logic [IN_W-1:0] pattern_a;
    logic [15:0]     signature_a;
    logic            busy_a, done_a, pass_a;
    logic [1:0]      state_a;

    // single-vector instance
    logic            start_b = 1'b0, abort_b = 1'b0, dut_out_b = 1'b0;
    logic [15:0]     golden_b = '0;
    logic [IN_W-1:0] pattern_b;
    logic [15:0]     signature_b;
    logic            busy_b, done_b, pass_b;
    logic [1:0]      state_b;

    // reference model tables: applied vectors and signature after k captures
    logic [IN_W-1:0] vec     [0:N_A];
    logic [15:0]     sig_ref [0:N_A];

    // scoreboard entries: {done cycle[31:0], pass, signature[15:0]}
    logic [48:0] exp_q_a[$];
    logic [48:0] exp_q_b[$];

    // stand-in combinational netlist under test
    function automatic logic net_fn(input logic [IN_W-1:0] p);
        return (^(p & 43'h5A5_A5A5_A5A5)) ^ (p[3] & p[40]) ^ (p[20] | p[7]);
    endfunction

    // CRC-16/CCITT polynomial division step with the response bit folded in
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        logic [16:0] wide;
        wide = {1'b0, s} * 17'd2;
        if (wide[16]) wide = wide ^ 17'h11021;
        return wide[15:0] ^ {15'b0, b};
    endfunction

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] p);
        logic fb;
        fb = p[42] ^ p[41] ^ p[37] ^ p[36];
        return (p << 1) | IN_W'(fb);
    endfunction

    assign dut_out_a = net_fn(pattern_a) ^ noise_a;

    netlist_bist_ctrl #(
        .IN_W(IN_W), .NUM_PATTERNS(N_A), .SETTLE_CYC(S_A),
        .SEED(43'h1), .TAPS(43'h630_0000_0000)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .golden_sig(golden_a), .dut_out(dut_out_a), .pattern(pattern_a),
        .signature(signature_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .state_dbg(state_a)
    );

    netlist_bist_ctrl #(
        .IN_W(IN_W), .NUM_PATTERNS(1), .SETTLE_CYC(0), .SEED(43'h1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .golden_sig(golden_b), .dut_out(dut_out_b), .pattern(pattern_b),
        .signature(signature_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .state_dbg(state_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a
        logic [48:0] e;
        if (done_a === 1'b1) begin
            if (exp_q_a.size() == 0) begin
                check("unexpected_done_a", done_a, 1'b0);
            end else begin
                e = exp_q_a.pop_front();
                check("sig_a", signature_a, e[15:0]);
                check("pass_a", pass_a, e[16]);
                check("busy_at_done_a", busy_a, 1'b0);
                check("done_cycle_a", cyc, e[48:17]);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [48:0] e;
        if (done_b === 1'b1) begin
            if (exp_q_b.size() == 0) begin
                check("unexpected_done_b", done_b, 1'b0);
            end else begin
                e = exp_q_b.pop_front();
                check("sig_b", signature_b, e[15:0]);
                check("pass_b", pass_b, e[16]);
                check("busy_at_done_b", busy_b, 1'b0);
                check("done_cycle_b", cyc, e[48:17]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic build_model();
        vec[0]     = 43'h1;
        sig_ref[0] = 16'hFFFF;
        for (int k = 0; k < N_A; k++) begin
            sig_ref[k+1] = misr_step(sig_ref[k], net_fn(vec[k]));
            vec[k+1]     = lfsr_step(vec[k]);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({"rst_pattern_a_", tag}, pattern_a, '0);
        check({"rst_sig_a_", tag}, signature_a, 16'hFFFF);
        check({"rst_busy_a_", tag}, busy_a, 1'b0);
        check({"rst_done_a_", tag}, done_a, 1'b0);
        check({"rst_pass_a_", tag}, pass_a, 1'b0);
    endtask

    // called at a negedge; start is sampled on the following posedge
    task automatic start_a_run(input logic [15:0] golden, input bit push);
        golden_a = golden;
        start_a  = 1'b1;
        if (push)
            exp_q_a.push_back({32'(cyc + N_A * (S_A + 1) + 1), golden == sig_ref[N_A], sig_ref[N_A]});
    endtask

    // walks nvec vectors cycle by cycle; returns at the negedge of the last capture cycle
    task automatic step_a(input int nvec, input bit noisy);
        for (int k = 0; k < nvec; k++) begin
            for (int j = 0; j <= S_A; j++) begin
                @(negedge clk);
                start_a = 1'b0;
                check("pattern_a", pattern_a, vec[k]);
                check("busy_a", busy_a, 1'b1);
                noise_a = (noisy && j < S_A) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    task automatic drain_a(input int budget);
        int i;
        i = 0;
        while (exp_q_a.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q_a.size() != 0) begin
            check("done_timeout_a", exp_q_a.size(), 0);
            exp_q_a.delete();
        end
    endtask

    task automatic drain_b(input int budget);
        int i;
        i = 0;
        while (exp_q_b.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q_b.size() != 0) begin
            check("done_timeout_b", exp_q_b.size(), 0);
            exp_q_b.delete();
        end
    endtask

    task automatic run_b(input logic [15:0] golden, input logic bitv);
        logic [15:0] es;
        es = misr_step(16'hFFFF, bitv);
        @(negedge clk);
        golden_b  = golden;
        dut_out_b = bitv;
        start_b   = 1'b1;
        exp_q_b.push_back({32'(cyc + 2), golden == es, es});
        @(negedge clk);
        start_b = 1'b0;
        check("pattern_b_first", pattern_b, vec[0]);
        check("busy_b_run", busy_b, 1'b1);
        drain_b(10);
        check("pattern_b_hold", pattern_b, vec[1]);
        check("sig_b_hold", signature_b, es);
        check("pass_b_hold", pass_b, golden == es);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [15:0] g;
        build_model();

        // reset held for two cycles
        repeat (2) @(negedge clk);
        check_reset_a("init");
        check("rst_pattern_b", pattern_b, '0);
        check("rst_sig_b", signature_b, 16'hFFFF);
        check("rst_busy_b", busy_b, 1'b0);
        check("rst_done_b", done_b, 1'b0);
        check("rst_pass_b", pass_b, 1'b0);
        rst = 1'b0;

        // single vector: known golden, wrong golden, random response bit
        run_b(16'hEFDF, 1'b0);
        run_b(16'h0000, 1'b0);
        run_b(misr_step(16'hFFFF, 1'b1), 1'b1);
        run_b(16'($urandom), 1'($urandom_range(0, 1)));

        // full run with response noise during settle cycles
        @(negedge clk);
        start_a_run(sig_ref[N_A], 1'b1);
        step_a(N_A, 1'b1);
        drain_a(20);
        check("pattern_final_a", pattern_a, vec[N_A]);
        check("sig_final_hold_a", signature_a, sig_ref[N_A]);

        // second start from DONE reproduces the signature
        @(negedge clk);
        start_a_run(sig_ref[N_A], 1'b1);
        step_a(N_A, 1'b0);
        drain_a(20);

        // abort in the capture cycle of pattern 10, with a start that must be ignored
        @(negedge clk);
        start_a_run(16'h0000, 1'b0);
        step_a(11, 1'b1);
        abort_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        start_a = 1'b0;
        check("abort_busy_a", busy_a, 1'b0);
        check("abort_done_a", done_a, 1'b0);
        check("abort_pattern_a", pattern_a, '0);
        check("abort_pass_a", pass_a, 1'b0);
        check("abort_sig_hold_a", signature_a, sig_ref[10]);
        repeat (4) begin
            @(negedge clk);
            check("idle_busy_a", busy_a, 1'b0);
            check("idle_pattern_a", pattern_a, '0);
        end

        // restart after abort, random golden
        g = 16'($urandom);
        start_a_run(g, 1'b1);
        step_a(N_A, 1'b1);
        drain_a(20);

        // reset during the capture cycle of pattern 5
        @(negedge clk);
        start_a_run(16'h0000, 1'b0);
        step_a(6, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_a("midrun");

        // clean run after the reset
        start_a_run(sig_ref[N_A], 1'b1);
        step_a(N_A, 1'b0);
        drain_a(20);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: bench did not complete, %0d errors so far", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/netlist_bist_ctrl.md
# netlist_bist_ctrl

- Built-in self-test sequencer for the generated ASAP7 combinational netlists (43 primary inputs, one primary output).
- On `start`, it does the following:
  - drives a pseudo-random stream of input vectors into the netlist under test;
  - waits a programmable settle time per vector;
  - compacts the netlist's 1-bit output into a 16-bit MISR signature;
  - compares the signature against a golden value.
- It sits between the test harness and one netlist instance and owns all of that instance's inputs during a run.

## Interface
Parameters:
- `IN_W`, 43, width of the pattern bus (netlist primary inputs).
- `NUM_PATTERNS`, 256, vectors applied per run (≥1).
- `SETTLE_CYC`, 2, idle cycles each vector is held before capture (≥0).
- `SEED`, 43'h1, LFSR seed. A value of 0 is replaced by 1.
- `TAPS`, 43'h630_0000_0000, LFSR feedback mask (bits 42, 41, 37, 36).

Ports:
- Reset convention: single clock `clk`; reset is synchronous and active-high (`rst`).
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: begin run. Sampled only in IDLE or DONE.
- `abort` in 1: cancel run. Returns to IDLE without `done`.
- `golden_sig` in 16: expected signature. Sampled on the final capture edge.
- `dut_out` in 1: netlist primary output.
- `pattern` out IN_W: netlist primary inputs.
- `signature` out 16: running MISR value.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: signature matched golden. Valid from `done`, held until next start.

## Operation
- States are IDLE, SETTLE, CAPTURE and DONE.
- **Reset values:** `pattern`=0, `signature`=16'hFFFF, `busy`=0, `done`=0, `pass`=0. State is IDLE; settle counter and pattern index are 0.
- **IDLE/DONE + `start`:** the next edge loads `pattern`=SEED (or 1), `signature`=16'hFFFF, index=0 and `pass`=0, and sets `busy`=1.
  - The next state is SETTLE if SETTLE_CYC>0, else CAPTURE.
- **SETTLE:** the counter increments each cycle. After SETTLE_CYC cycles the state moves to CAPTURE.
- **CAPTURE** (one cycle), on the edge leaving it:
  - MISR update: `sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, dut_out}`.
  - LFSR advance: `fb = ^(pattern & TAPS)`, `pattern <= {pattern[IN_W-2:0], fb}`.
  - Index increments.
  - If the index reaches NUM_PATTERNS, the next state is DONE:
    - `pass <= (next signature == golden_sig)`;
    - `busy <= 0`;
    - `done <= 1` for exactly one cycle.
  - Otherwise the next state is SETTLE (or CAPTURE if SETTLE_CYC=0).
- **DONE:** `pattern` and `signature` hold their final values. The block stays in DONE until `start` (new run) or `rst`.
- **`abort`** in SETTLE or CAPTURE:
  - next state IDLE, `busy`=0, `pattern`=0, `pass`=0;
  - no `done`, no MISR update on that edge;
  - `signature` holds its last value.
- **Simultaneous events:**
  - `abort` has priority over CAPTURE completion.
  - `start` while busy is ignored.
  - `start` and `abort` together in IDLE are treated as `start`.
- **`rst`** overrides everything, including mid-run.
- Index counter width is `$clog2(NUM_PATTERNS+1)`. There is no wrap-around within a run.

## Timing
- Each vector is stable on `pattern` for SETTLE_CYC+1 cycles. `dut_out` is sampled at the end of the last of them.
- Latency from the `start` edge to `done` high is NUM_PATTERNS×(SETTLE_CYC+1)+1 cycles.
- `busy` is high from the cycle after `start` through the final CAPTURE, and low in the `done` cycle.
- Outputs are registered. `dut_out` is the only combinational path from outside (netlist loop) and is sampled only in CAPTURE.

## Test plan
- **Reset:** assert `rst` 2 cycles. Required: `pattern`=0, `signature`=16'hFFFF, `busy`=`done`=`pass`=0.
- **Single vector:** NUM_PATTERNS=1, SETTLE_CYC=0, SEED=1, `dut_out`=0, `golden_sig`=16'hEFDF, `start`.
  - `pattern`=1 for 1 cycle.
  - `done` 2 cycles after `start`.
  - `signature`=16'hEFDF, `pass`=1.
  - Repeating with `golden_sig`=16'h0000 gives `pass`=0.
- **LFSR and settle:** SEED=1, SETTLE_CYC=2.
  - `pattern` sequence is 1, 2, 4, … with each value held 3 cycles.
  - `dut_out` toggled during SETTLE cycles must not affect `signature`.
- **Full run on a netlist instance:** default parameters.
  - `done` at cycle 769 after `start`.
  - `signature` equals the reference-model MISR over 256 LFSR vectors.
  - A second `start` from DONE reproduces the identical signature.
- **Abort and restart:** `abort` in pattern 10.
  - Next cycle: IDLE, `busy`=0, no `done`, `pattern`=0.
  - `start` in the same cycle as `abort` while busy is ignored.
  - A subsequent `start` yields the same signature as an uninterrupted run.
- **Mid-run reset:** `rst` in CAPTURE of pattern 5.
  - All outputs return to their reset values the next cycle.
  - `start` afterwards runs correctly.
